// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM for an iterative AES core.
// It accepts one block at a time, steps the round-key index and datapath
// select through the initial AddRoundKey, NR-1 middle rounds and the last
// round, and then holds the result until the consumer takes it.
// Optional feature macro: AES_SEQ_ABORT_EN adds an 'abort' input that
// cancels a block while its rounds are running.
module aes_round_sequencer #(
    parameter int NR    = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef AES_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             decrypt,
    input  logic             key_ready,
    output logic [3:0]       round_idx,
    output logic [1:0]       round_sel,
    output logic             state_load,
    output logic             mode,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CNT_W-1:0] blocks_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_MID,
        S_LAST,
        S_DONE
    } state_t;

    localparam logic [3:0] NR_IDX      = 4'(NR);
    localparam logic [3:0] MID_CNT_END = 4'(NR - 2);

    localparam logic [1:0] SEL_INIT = 2'b00;
    localparam logic [1:0] SEL_MID  = 2'b01;
    localparam logic [1:0] SEL_LAST = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] mid_cnt;    // middle rounds already applied (0 .. NR-2)
    logic       armed;      // low for the first cycle after reset
    logic       accept;
    logic       handshake;
    logic       abort_req;

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every
        // register samples the pre-edge values, independent of block order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-block context: mode latch, middle-round counter, completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            mode        <= 1'b0;
            mid_cnt     <= 4'd0;
            blocks_done <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                mode <= decrypt;
            end
            if (state == S_FIRST) begin
                mid_cnt <= 4'd0;
            end else if (state == S_MID) begin
                mid_cnt <= mid_cnt + 4'd1;
            end
            if (handshake) begin
                blocks_done <= blocks_done + CNT_W'(1);
            end
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a signal unassigned and infer a latch.
        state_nxt   = state;
        start_ready = 1'b0;
        accept      = 1'b0;
        handshake   = 1'b0;
        round_sel   = SEL_IDLE;
        round_idx   = 4'd0;
        state_load  = 1'b0;
        done_valid  = 1'b0;

        case (state)
            S_IDLE: begin
                start_ready = armed & key_ready;
                accept      = start_valid & start_ready;
                if (accept) begin
                    state_nxt = S_FIRST;
                end
            end
            S_FIRST: begin
                round_sel  = SEL_INIT;
                state_load = 1'b1;
                round_idx  = mode ? NR_IDX : 4'd0;
                state_nxt  = abort_req ? S_IDLE : S_MID;
            end
            S_MID: begin
                round_sel  = SEL_MID;
                state_load = 1'b1;
                round_idx  = mode ? (NR_IDX - 4'd1 - mid_cnt) : (mid_cnt + 4'd1);
                if (abort_req) begin
                    state_nxt = S_IDLE;
                end else if (mid_cnt == MID_CNT_END) begin
                    state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                round_sel  = SEL_LAST;
                state_load = 1'b1;
                round_idx  = mode ? 4'd0 : NR_IDX;
                state_nxt  = abort_req ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done_valid = 1'b1;
                handshake  = done_ready;
                if (done_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule
